// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory bus between the instruction-fetch (IF)
//   port and the data-memory (MEM) port of the pipeline.
//   When both ports request at once, the grant alternates between them.
//   Each port gets a one-cycle ack pulse and a combinational stall flag.
//   A watchdog ends any access that waits too long for bus_ready_i. It
//   completes the access with zero data and sets a sticky error flag.
//
// Ports
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   if_*_i / if_*_o  fetch request, address, flush in; fetched data and ack out
//   mem_*_i / *_o    data request, we, address, store data in; load data and ack out
//   stall_*_o        port request pending and not yet acknowledged
//   bus_*_o          registered memory bus request, we, address, write data
//   bus_rdata_i      bus read data, valid together with bus_ready_i
//   bus_ready_i      completion of the current bus access
//   bus_err_o        sticky watchdog timeout flag
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ack_o,
  output logic              stall_if_o,
  output logic              stall_mem_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ready_i,
  output logic              bus_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, IF_ACC, MEM_ACC} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_grant_mem_q;
  logic              flush_pending_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic              if_ack_q;
  logic              mem_ack_q;
  logic              bus_req_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic              bus_err_q;

  logic arb_en;
  logic grant_mem;
  logic grant_if;
  logic timeout_hit;
  logic flush_now;

  always_comb begin
    // A requester may still hold a stale req in its ack cycle, so no
    // arbitration takes place while either ack is high. This also gives
    // the idle turnaround cycle after every access.
    arb_en      = (state_q == IDLE) && !if_ack_q && !mem_ack_q;
    grant_mem   = arb_en && mem_req_i && (!if_req_i || !last_grant_mem_q);
    grant_if    = arb_en && if_req_i && !grant_mem;
    // cnt_q counts the cycles already spent waiting. The access whose
    // TIMEOUT-th cycle passes without bus_ready is the one that times out.
    timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    flush_now   = flush_pending_q || if_flush_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      last_grant_mem_q <= 1'b0;
      flush_pending_q  <= 1'b0;
      if_rdata_q       <= '0;
      mem_rdata_q      <= '0;
      if_ack_q         <= 1'b0;
      mem_ack_q        <= 1'b0;
      bus_req_q        <= 1'b0;
      bus_we_q         <= 1'b0;
      bus_addr_q       <= '0;
      bus_wdata_q      <= '0;
      bus_err_q        <= 1'b0;
    end else begin
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_mem) begin
            state_q          <= MEM_ACC;
            bus_req_q        <= 1'b1;
            bus_we_q         <= mem_we_i;
            bus_addr_q       <= mem_addr_i;
            bus_wdata_q      <= mem_wdata_i;
            last_grant_mem_q <= 1'b1;
            cnt_q            <= '0;
          end else if (grant_if) begin
            state_q          <= IF_ACC;
            bus_req_q        <= 1'b1;
            bus_we_q         <= 1'b0;
            bus_addr_q       <= if_addr_i;
            last_grant_mem_q <= 1'b0;
            cnt_q            <= '0;
            // A branch resolving in the grant cycle already kills this fetch.
            flush_pending_q  <= if_flush_i;
          end
        end
        IF_ACC: begin
          if (bus_ready_i || timeout_hit) begin
            state_q         <= IDLE;
            bus_req_q       <= 1'b0;
            flush_pending_q <= 1'b0;
            if (!bus_ready_i) bus_err_q <= 1'b1;
            // A flushed fetch still finishes its bus handshake, but the
            // fetch stage has already moved on, so its result is dropped.
            if (!flush_now) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= bus_ready_i ? bus_rdata_i : '0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (if_flush_i) flush_pending_q <= 1'b1;
          end
        end
        MEM_ACC: begin
          if (bus_ready_i || timeout_hit) begin
            state_q   <= IDLE;
            bus_req_q <= 1'b0;
            mem_ack_q <= 1'b1;
            if (!bus_ready_i) bus_err_q <= 1'b1;
            // A store returns no data, so mem_rdata keeps the last load.
            if (!bus_we_q) mem_rdata_q <= bus_ready_i ? bus_rdata_i : '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_rdata_o  = if_rdata_q;
  assign mem_rdata_o = mem_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign mem_ack_o   = mem_ack_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_err_o   = bus_err_q;
  assign stall_if_o  = if_req_i & ~if_ack_q;
  assign stall_mem_o = mem_req_i & ~mem_ack_q;

endmodule
